chip8_mem_arbiter: RTL and testbench
====================================

# chip8_mem_arbiter

Single-clock arbiter and sequencer for port A of the CHIP-8 4 KB program/font memory, which is built as two 4-bit BRAM halves with unregistered outputs. It shares the port between three requesters: the program loader (write-only), the CPU core (fetch/load/store) and the sprite draw engine (read-only). It also runs a load session that holds the CPU off while a ROM image is written. Port B (video readout) is untouched by this block.

## Interface
- `ADDR_W`, 12: memory address width (4096 bytes).
- `DATA_W`, 8: data width.
- `PROT_TOP`, 12'h200: first CPU-writable address when write protection is compiled in.
- `clk` in 1: single clock; also drives memory port A.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ld_start` in 1: one-cycle pulse; opens a load session.
- `ld_done` in 1: one-cycle pulse; closes the load session.
- `ld_req` in 1, `ld_addr` in ADDR_W, `ld_wdata` in DATA_W: loader write request.
- `ld_ack` out 1: loader write accepted this cycle.
- `ld_count` out ADDR_W+1: bytes written in the current or last session.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in ADDR_W, `cpu_wdata` in DATA_W: CPU request.
- `cpu_ack` out 1, `cpu_rvalid` out 1, `cpu_hold` out 1: CPU handshake; `cpu_hold` is high during a load session.
- `drw_req` in 1, `drw_addr` in ADDR_W: draw-engine read request.
- `drw_ack` out 1, `drw_rvalid` out 1: draw handshake.
- `rdata` out DATA_W: read data, shared by both readers; qualified by the matching rvalid.
- `mem_en`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W; `mem_rdata` in DATA_W: memory port A.
- `wp_err` out 1: sticky protection-violation flag. Only present with the macro; otherwise tied to 0.

## Operation
- The FSM has two states: RUN and LOAD. Reset state is RUN.
- RUN to LOAD on `ld_start`. LOAD to RUN on `ld_done`.
- If `ld_start` and `ld_done` arrive in the same cycle, `ld_done` wins and the state becomes or stays RUN.
- Entering LOAD clears `ld_count` to 0. `ld_count` holds its value after returning to RUN.
- LOAD state:
  - Only `ld_req` can be granted; `cpu_ack` and `drw_ack` stay 0.
  - `cpu_hold` is 1.
  - Each `ld_ack` increments `ld_count`, saturating at 4096.
- RUN state:
  - `ld_req` is ignored.
  - CPU and draw requests use round-robin arbitration via a `prio` bit. Reset value is 0, meaning the CPU is favoured.
  - Grant to the CPU sets `prio` to 1; grant to draw sets `prio` to 0.
  - A lone requester is always granted.
- Handshake:
  - A requester holds `req` and its address/data stable until it sees `ack`.
  - `ack` is combinational from `req`, state and `prio`.
  - At most one ack per cycle.
- Memory drive:
  - On any ack: `mem_en`=1, `mem_addr` and `mem_wdata` come from the winner, `mem_we`=1 for loader and CPU writes.
  - With no ack, `mem_en`=0.
- Read return: a one-bit tag register records which reader issued a read.
  - One cycle after that ack, the matching rvalid pulses for one cycle.
  - `rdata` = `mem_rdata` in that cycle.
  - Writes never produce rvalid.
- Back-to-back reads from alternating requesters pipeline at one access per cycle.

## Timing
- Read latency: ack in cycle N, rvalid and data in cycle N+1.
- Write completes at the ack edge.
- Reset values:
  - `cpu_hold`=0, all acks 0, all rvalids 0.
  - `mem_en`=0, `mem_we`=0.
  - `ld_count`=0, `wp_err`=0, `prio`=0, tag cleared.
- Asserting `rst_n` mid-read discards the pending rvalid. No rvalid appears after reset is released.
- Entering LOAD while a read is pending still delivers that rvalid in the next cycle.

## Configuration
- `CHIP8_MEM_WRPROT_EN` defined:
  - A CPU write with `cpu_addr` < `PROT_TOP` is still acked, but `mem_en`=0 and `mem_we`=0, so memory is unchanged.
  - `wp_err` is set and stays set until reset.
  - Loader writes are exempt.
- Macro undefined: no protection; `wp_err` is constant 0.

## Structure
- Shared package `chip8_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `PROT_TOP` constant.
  - `arb_state_t` enum {RUN, LOAD}.
  - `rd_tag_t` enum {TAG_CPU, TAG_DRW}.
- One natural sub-module: `chip8_rr_arb2`, the two-way round-robin picker holding the `prio` bit.

## Test plan
- Reset, then CPU read of 0x200 containing 0x6A: `cpu_ack` in cycle 0; `cpu_rvalid`=1 and `rdata`=0x6A in cycle 1; `drw_rvalid`=0.
- CPU and draw request together for 4 cycles: acks alternate CPU, draw, CPU, draw; rvalids follow one cycle later with correct data.
- `ld_start`, then 3 loader writes of 0x12, 0x34, 0x56 to 0x200..0x202, then `ld_done`:
  - `cpu_hold`=1 throughout and `cpu_req` is never acked.
  - `ld_count`=3.
  - CPU reads afterwards return the written bytes.
- `ld_req` in RUN: never acked; `ld_count` unchanged.
- With `CHIP8_MEM_WRPROT_EN`: CPU write of 0xFF to 0x050 is acked with `mem_we`=0, `wp_err` goes to 1, and a read of 0x050 returns the original font byte. A CPU write to 0x200 succeeds.
- `rst_n` low in the cycle after a draw ack: no `drw_rvalid`, and all outputs return to reset values.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 program/font memory port-A arbiter.
package chip8_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] PROT_TOP   = 12'h200;
  localparam logic [CNT_W-1:0]  LD_CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } arb_state_t;

  typedef enum logic {
    TAG_CPU = 1'b0,
    TAG_DRW = 1'b1
  } rd_tag_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/chip8_rr_arb2.sv
// Two-way round-robin picker between CPU and draw engine; owns the prio bit.
module chip8_rr_arb2
  import chip8_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_cpu,
  input  logic i_req_drw,
  output logic o_gnt_cpu_c,
  output logic o_gnt_drw_c
);

  // 0 favours the CPU, 1 favours the draw engine
  logic r_prio;

  always_comb begin
    o_gnt_cpu_c = i_en & i_req_cpu & (~i_req_drw | ~r_prio);
    o_gnt_drw_c = i_en & i_req_drw & (~i_req_cpu |  r_prio);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (o_gnt_cpu_c) begin
      r_prio <= 1'b1;
    end else if (o_gnt_drw_c) begin
      r_prio <= 1'b0;
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Port-A arbiter/sequencer for the CHIP-8 4 KB memory: loader, CPU and draw engine.
// Optional CPU write protection below PROT_TOP: define CHIP8_MEM_WRPROT_EN.
module chip8_mem_arbiter
  import chip8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_start,
  input  logic              i_ld_done,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  output logic              o_ld_ack,
  output logic [CNT_W-1:0]  o_ld_count,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_rvalid,
  output logic              o_cpu_hold,
  input  logic              i_drw_req,
  input  logic [ADDR_W-1:0] i_drw_addr,
  output logic              o_drw_ack,
  output logic              o_drw_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wp_err
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             w_arb_en;
  logic             w_gnt_cpu;
  logic             w_gnt_drw;
  logic             w_wp_blk;
  mem_req_t         w_mem;
  logic             r_rd_pend;
  rd_tag_t          r_rd_tag;
  logic [CNT_W-1:0] r_ld_count;

  assign w_arb_en = (r_state == RUN);

  chip8_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_arb_en),
    .i_req_cpu   (i_cpu_req),
    .i_req_drw   (i_drw_req),
    .o_gnt_cpu_c (w_gnt_cpu),
    .o_gnt_drw_c (w_gnt_drw)
  );

`ifdef CHIP8_MEM_WRPROT_EN
  assign w_wp_blk = i_cpu_we && (i_cpu_addr < PROT_TOP);
`else
  assign w_wp_blk = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grants and the winning memory request
  always_comb begin
    w_state_nxt = r_state;
    o_ld_ack    = 1'b0;
    o_cpu_ack   = 1'b0;
    o_drw_ack   = 1'b0;
    w_mem       = '0;
    unique case (r_state)
      RUN: begin
        o_cpu_ack = w_gnt_cpu;
        o_drw_ack = w_gnt_drw;
        if (i_ld_start && !i_ld_done) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        o_ld_ack = i_ld_req;
        if (i_ld_done) begin
          w_state_nxt = RUN;
        end
      end
    endcase
    if (o_ld_ack) begin
      w_mem.en    = 1'b1;
      w_mem.we    = 1'b1;
      w_mem.addr  = i_ld_addr;
      w_mem.wdata = i_ld_wdata;
    end else if (o_cpu_ack) begin
      // A protected write is acked but never reaches the memory
      w_mem.en    = ~w_wp_blk;
      w_mem.we    = i_cpu_we & ~w_wp_blk;
      w_mem.addr  = i_cpu_addr;
      w_mem.wdata = i_cpu_wdata;
    end else if (o_drw_ack) begin
      w_mem.en    = 1'b1;
      w_mem.addr  = i_drw_addr;
    end
  end

  // Read-return tag: the memory answers one cycle after the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_tag  <= TAG_CPU;
    end else begin
      r_rd_pend <= (o_cpu_ack & ~i_cpu_we) | o_drw_ack;
      r_rd_tag  <= o_drw_ack ? TAG_DRW : TAG_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_count <= '0;
    end else if ((r_state == RUN) && (w_state_nxt == LOAD)) begin
      r_ld_count <= '0;
    end else if (o_ld_ack && (r_ld_count != LD_CNT_MAX)) begin
      r_ld_count <= r_ld_count + CNT_W'(1);
    end
  end

`ifdef CHIP8_MEM_WRPROT_EN
  logic r_wp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp_err <= 1'b0;
    end else if (o_cpu_ack && w_wp_blk) begin
      r_wp_err <= 1'b1;
    end
  end

  assign o_wp_err = r_wp_err;
`else
  assign o_wp_err = 1'b0;
`endif

  assign o_mem_en     = w_mem.en;
  assign o_mem_we     = w_mem.we;
  assign o_mem_addr   = w_mem.addr;
  assign o_mem_wdata  = w_mem.wdata;
  assign o_rdata      = i_mem_rdata;
  assign o_cpu_rvalid = r_rd_pend && (r_rd_tag == TAG_CPU);
  assign o_drw_rvalid = r_rd_pend && (r_rd_tag == TAG_DRW);
  assign o_cpu_hold   = (r_state == LOAD);
  assign o_ld_count   = r_ld_count;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed vector table, random traffic against a
// transaction-level model, load-count saturation and mid-read reset.
module tb_chip8_mem_arbiter;
  import chip8_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ld_start, ld_done, ld_req;
  logic [11:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic [12:0] ld_count;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid, cpu_hold;
  logic        drw_req;
  logic [11:0] drw_addr;
  logic        drw_ack, drw_rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wp_err;

  chip8_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_ld_start(ld_start), .i_ld_done(ld_done), .i_ld_req(ld_req),
    .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .o_ld_ack(ld_ack), .o_ld_count(ld_count),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rvalid(cpu_rvalid), .o_cpu_hold(cpu_hold),
    .i_drw_req(drw_req), .i_drw_addr(drw_addr), .o_drw_ack(drw_ack), .o_drw_rvalid(drw_rvalid),
    .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_wp_err(wp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM half-pair: registered address, unregistered output
  logic [7:0] bram [4096];
  logic [7:0] bram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        bram_q <= bram[mem_addr];
    end
  end
  assign mem_rdata = bram_q;

  function automatic logic [7:0] init_byte(input int a);
    return (a == 32'h200) ? 8'h6A : 8'(a * 7 + 3);
  endfunction

  // Reference model state
  bit         m_load, m_prio, m_pend, m_pend_cpu, m_wp;
  int         m_count;
  logic [7:0] m_rd;
  logic [7:0] ref_mem [4096];
  bit         e_ld, e_cpu, e_drw, e_prot, e_en, e_we;
  logic [11:0] e_addr;
  logic [7:0]  e_wd;

  int n_pass, n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_load = 0; m_prio = 0; m_pend = 0; m_pend_cpu = 0; m_wp = 0; m_count = 0;
  endtask

  task automatic model_check();
    e_ld  = m_load && ld_req;
    e_cpu = !m_load && cpu_req && (!drw_req || !m_prio);
    e_drw = !m_load && drw_req && (!cpu_req || m_prio);
`ifdef CHIP8_MEM_WRPROT_EN
    e_prot = e_cpu && cpu_we && (cpu_addr < 12'h200);
`else
    e_prot = 0;
`endif
    e_en   = (e_ld || e_cpu || e_drw) && !e_prot;
    e_we   = e_ld || (e_cpu && cpu_we && !e_prot);
    e_addr = e_ld ? ld_addr : (e_cpu ? cpu_addr : drw_addr);
    e_wd   = e_ld ? ld_wdata : cpu_wdata;
    chk("ld_ack",  int'(ld_ack),  int'(e_ld));
    chk("cpu_ack", int'(cpu_ack), int'(e_cpu));
    chk("drw_ack", int'(drw_ack), int'(e_drw));
    chk("mem_en",  int'(mem_en),  int'(e_en));
    chk("mem_we",  int'(mem_we),  int'(e_we));
    if (e_en) chk("mem_addr",  int'(mem_addr),  int'(e_addr));
    if (e_we) chk("mem_wdata", int'(mem_wdata), int'(e_wd));
    chk("cpu_rvalid", int'(cpu_rvalid), int'(m_pend && m_pend_cpu));
    chk("drw_rvalid", int'(drw_rvalid), int'(m_pend && !m_pend_cpu));
    if (m_pend) chk("rdata", int'(rdata), int'(m_rd));
    chk("cpu_hold", int'(cpu_hold), int'(m_load));
    chk("ld_count", int'(ld_count), m_count);
    chk("wp_err",   int'(wp_err),   int'(m_wp));
  endtask

  task automatic model_update();
    m_pend     = (e_cpu && !cpu_we) || e_drw;
    m_pend_cpu = e_cpu;
    if (m_pend) m_rd = ref_mem[e_addr];
    if (e_we) ref_mem[e_addr] = e_wd;
    if (e_cpu) m_prio = 1;
    else if (e_drw) m_prio = 0;
    if (e_prot) m_wp = 1;
    if (e_ld && m_count < 4096) m_count++;
    if (ld_done) m_load = 0;
    else if (ld_start && !m_load) begin m_load = 1; m_count = 0; end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ld_start = 0; ld_done = 0; ld_req = 0; ld_addr = '0; ld_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    drw_req = 0; drw_addr = '0;
  endtask

  // acks = {cpu_ack, drw_ack, ld_ack, cpu_rvalid, drw_rvalid}
  typedef struct {
    bit st, dn, lr; logic [11:0] la; logic [7:0] lw;
    bit cr, cw; logic [11:0] ca; logic [7:0] cd;
    bit dr; logic [11:0] da;
    logic [4:0] acks; logic [7:0] rd; bit hold; int cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  logic [7:0] font50_exp;

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 4096; i++) begin
      bram[i] = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
    bram_q = '0;
`ifdef CHIP8_MEM_WRPROT_EN
    font50_exp = init_byte(12'h050);
`else
    font50_exp = 8'hFF;
`endif
    //          st dn lr la      lw     cr cw ca      cd     dr da       acks      rd                hold cnt
    tbl[0]  = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h200, 8'h0,  0, 12'h0,   5'b10000, 8'h00,             0, 0};
    tbl[1]  = '{0, 0, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  1, 12'h010, 5'b01010, 8'h6A,             0, 0};
    tbl[2]  = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h201, 8'h0,  1, 12'h300, 5'b10001, init_byte(12'h010), 0, 0};
    tbl[3]  = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h202, 8'h0,  1, 12'h300, 5'b01010, init_byte(12'h201), 0, 0};
    tbl[4]  = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h202, 8'h0,  1, 12'h301, 5'b10001, init_byte(12'h300), 0, 0};
    tbl[5]  = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h203, 8'h0,  1, 12'h301, 5'b01010, init_byte(12'h202), 0, 0};
    tbl[6]  = '{1, 0, 0, 12'h0,   8'h0,  1, 0, 12'h204, 8'h0,  0, 12'h0,   5'b10001, init_byte(12'h301), 0, 0};
    tbl[7]  = '{0, 0, 1, 12'h200, 8'h12, 1, 0, 12'h205, 8'h0,  0, 12'h0,   5'b00110, init_byte(12'h204), 1, 0};
    tbl[8]  = '{0, 0, 1, 12'h201, 8'h34, 1, 0, 12'h205, 8'h0,  0, 12'h0,   5'b00100, 8'h00,             1, 1};
    tbl[9]  = '{0, 0, 1, 12'h202, 8'h56, 1, 0, 12'h205, 8'h0,  0, 12'h0,   5'b00100, 8'h00,             1, 2};
    tbl[10] = '{0, 1, 0, 12'h0,   8'h0,  1, 0, 12'h205, 8'h0,  0, 12'h0,   5'b00000, 8'h00,             1, 3};
    tbl[11] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h205, 8'h0,  0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[12] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h200, 8'h0,  0, 12'h0,   5'b10010, init_byte(12'h205), 0, 3};
    tbl[13] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h201, 8'h0,  0, 12'h0,   5'b10010, 8'h12,             0, 3};
    tbl[14] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h202, 8'h0,  0, 12'h0,   5'b10010, 8'h34,             0, 3};
    tbl[15] = '{0, 0, 1, 12'h210, 8'h99, 0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00010, 8'h56,             0, 3};
    tbl[16] = '{0, 0, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00000, 8'h00,             0, 3};
    tbl[17] = '{0, 0, 0, 12'h0,   8'h0,  1, 1, 12'h050, 8'hFF, 0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[18] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h050, 8'h0,  0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[19] = '{0, 0, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00010, font50_exp,        0, 3};
    tbl[20] = '{0, 0, 0, 12'h0,   8'h0,  1, 1, 12'h200, 8'hAB, 0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[21] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h200, 8'h0,  0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[22] = '{0, 0, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00010, 8'hAB,             0, 3};
    tbl[23] = '{1, 1, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00000, 8'h00,             0, 3};
    tbl[24] = '{0, 0, 0, 12'h0,   8'h0,  1, 0, 12'h203, 8'h0,  0, 12'h0,   5'b10000, 8'h00,             0, 3};
    tbl[25] = '{0, 0, 0, 12'h0,   8'h0,  0, 0, 12'h0,   8'h0,  0, 12'h0,   5'b00010, init_byte(12'h203), 0, 3};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    model_check();
    rst_n = 1'b1;
    finish_cycle();

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      ld_start = tbl[i].st; ld_done = tbl[i].dn; ld_req = tbl[i].lr;
      ld_addr = tbl[i].la; ld_wdata = tbl[i].lw;
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      drw_req = tbl[i].dr; drw_addr = tbl[i].da;
      #3;
      model_check();
      chk($sformatf("tbl%0d_acks", i), int'({cpu_ack, drw_ack, ld_ack, cpu_rvalid, drw_rvalid}),
          int'(tbl[i].acks));
      if (tbl[i].acks[1] || tbl[i].acks[0])
        chk($sformatf("tbl%0d_rdata", i), int'(rdata), int'(tbl[i].rd));
      chk($sformatf("tbl%0d_hold", i), int'(cpu_hold), int'(tbl[i].hold));
      chk($sformatf("tbl%0d_count", i), int'(ld_count), tbl[i].cnt);
      finish_cycle();
    end

    // Random traffic; requesters hold until acked
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      if (!cpu_req && $urandom_range(0, 2) != 0) begin
        cpu_req = 1; cpu_we = ($urandom_range(0, 3) == 0);
        cpu_addr = 12'($urandom); cpu_wdata = 8'($urandom);
      end
      if (!drw_req && $urandom_range(0, 2) != 0) begin
        drw_req = 1; drw_addr = 12'($urandom);
      end
      ld_req   = ($urandom_range(0, 1) == 1);
      ld_addr  = 12'($urandom);
      ld_wdata = 8'($urandom);
      ld_start = !m_load && ($urandom_range(0, 39) == 0);
      ld_done  = m_load ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 49) == 0);
      #3;
      model_check();
      finish_cycle();
      if (e_cpu) cpu_req = 0;
      if (e_drw) drw_req = 0;
    end

    // Load count saturates at 4096
    idle_inputs();
    ld_done = 1;
    #3; model_check(); finish_cycle();
    ld_done = 0; ld_start = 1;
    #3; model_check(); finish_cycle();
    ld_start = 0;
    for (int c = 0; c < 4100; c++) begin
      ld_req = 1; ld_addr = 12'($urandom); ld_wdata = 8'($urandom);
      #3; model_check(); finish_cycle();
    end
    ld_req = 0;
    #3;
    chk("ld_count_sat", int'(ld_count), 4096);
    ld_done = 1;
    model_check(); finish_cycle();
    idle_inputs();

    // Reset while a draw read is outstanding
    drw_req = 1; drw_addr = 12'h123;
    #3; model_check(); finish_cycle();
    drw_req = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_drw_rvalid", int'(drw_rvalid), 0);
    chk("rst_cpu_rvalid", int'(cpu_rvalid), 0);
    chk("rst_hold", int'(cpu_hold), 0);
    chk("rst_count", int'(ld_count), 0);
    chk("rst_wp_err", int'(wp_err), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_acks", int'({cpu_ack, drw_ack, ld_ack}), 0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #3; model_check(); finish_cycle();
    // Prio back to CPU-favoured after reset
    cpu_req = 1; cpu_addr = 12'h300; drw_req = 1; drw_addr = 12'h301;
    #3; model_check();
    chk("post_rst_prio", int'({cpu_ack, drw_ack}), 2);
    finish_cycle();
    cpu_req = 0;
    #3; model_check(); finish_cycle();
    drw_req = 0;
    #3; model_check(); finish_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
